branch_commit_unit: RTL
=======================

// Module: branch_commit_unit
// PURPOSE
//  Producer side of the predictor's branch-commit interface. It carries each fetched instruction's
//  BTB lookup result through the IF/ID, ID/EX and EX/MEM registers.
//  In EX it resolves the branch condition, the target address and the BTB index/tag.
//  In MEM it drives the EXMEM_* resolution signals consumed by the branch predictor.
//  It also keeps saturating counters of committed branches and mispredictions.
// PARAMETERS
//  INDEX_WIDTH  12  BTB index width; the BTB tag is 32-INDEX_WIDTH-2 bits wide.
//  CNT_WIDTH    32  Width of each performance counter.
// PORTS
//  clk_i                 in   1    Clock; all state updates on the rising edge.
//  rst_i                 in   1    Reset; asynchronous, active-high.
//  stall_i               in   1    Load-use stall: hold IF/ID, insert a bubble into ID/EX.
//  flush_i               in   1    Predictor's IF_flush_o: squash the IF/ID and ID/EX entries.
//  IF_valid_i            in   1    A valid instruction is in the IF stage.
//  IF_pc_i               in   32   PC of the fetched instruction.
//  IF_btb_hit_i          in   1    Predictor's IF_btb_hit_o for this PC.
//  ID_is_br_i            in   1    Decoded instruction is a conditional branch.
//  ID_br_funct3_i        in   3    Branch funct3.
//  ID_is_uncbr_i         in   2    2'b10 = JAL, 2'b11 = JALR, 2'b0x = neither.
//  EX_rs1_i/EX_rs2_i     in   32   Forwarded operands.
//  EX_imm_i              in   32   Sign-extended immediate.
//  EXMEM_btb_wr_index_o  out  INDEX_WIDTH  PC[INDEX_WIDTH+1:2].
//  EXMEM_btb_wr_tag_o    out  32-INDEX_WIDTH-2  PC[31:INDEX_WIDTH+2].
//  EXMEM_btb_wr_target_o out  32   Resolved target (same value as EXMEM_br_target_o).
//  EXMEM_br_target_o     out  32   Recovery target for PCnext_sel 2'b11.
//  EXMEM_pcplus4_o       out  32   PC+4, recovery address for PCnext_sel 2'b01.
//  EXMEM_btb_hit_o       out  1    IF_btb_hit as sampled when the instruction was fetched.
//  EXMEM_br_decision_o   out  1    Taken (conditional branch) or 1 (JAL/JALR).
//  EXMEM_is_br_o         out  1    Valid conditional branch.
//  EXMEM_is_uncbr_o      out  2    Valid JAL/JALR encoding.
//  EXMEM_mispredict_o    out  1    Resolution disagrees with the fetch-time prediction.
//  br_cnt_o              out  CNT_WIDTH  Count of committed branches, JALs and JALRs.
//  mispred_cnt_o         out  CNT_WIDTH  Count of committed mispredictions.
// BEHAVIOUR
//  - Reset: while rst_i is high, immediately and regardless of clk_i:
//    all stage valid bits = 0, every output = 0, both counters = 0.
//  - Latency: an instruction captured with IF_valid_i in cycle N appears on the EXMEM_* outputs
//    in cycle N+3, provided it is not stalled or flushed.
//    ID_* inputs are sampled in cycle N+1; EX_* inputs are sampled in cycle N+2.
//  - Register control, in priority order:
//    - flush_i: IF/ID.valid <= 0, ID/EX.valid <= 0, EX/MEM.valid <= 0.
//      This entry is the wrong-path EX instruction; the MEM branch has already committed.
//      flush_i wins over stall_i.
//    - stall_i: IF/ID holds, ID/EX.valid <= 0, EX/MEM advances normally.
//    - otherwise: all registers advance.
//    - EX/MEM never stalls, so each instruction occupies it for exactly one cycle.
//  - EX resolution:
//    - Conditional branch, decided by funct3:
//      - 000 BEQ; 001 BNE.
//      - 100 BLT; 101 BGE (signed compare).
//      - 110 BLTU; 111 BGEU (unsigned compare).
//      - 010 and 011 give decision 0.
//    - Target:
//      - Conditional branch or JAL: PC + imm, mod 2^32.
//      - JALR: (rs1 + imm) & 32'hFFFF_FFFE.
//    - JAL and JALR: decision = 1.
//  - Outputs gating: when EX/MEM.valid = 0, EXMEM_is_br_o, EXMEM_is_uncbr_o,
//    EXMEM_br_decision_o, EXMEM_btb_hit_o and EXMEM_mispredict_o are all 0.
//  - EXMEM_mispredict_o = valid & (JALR | ((is_br | JAL) & (btb_hit != decision))).
//    This matches exactly the cases where the predictor asserts IF_flush_o.
//  - Counters: each cycle, br_cnt increments by 1 if EX/MEM is a valid branch, JAL or JALR;
//    mispred_cnt increments by 1 on EXMEM_mispredict_o.
//    Both saturate at all-ones and never wrap.
//  - Registers and counters are state; the EXMEM_* outputs come straight from the EX/MEM register.
// STRUCTURE
//  - Package branch_pkg:
//    - funct3 localparams: F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
//    - UNCBR_JAL = 2'b10, UNCBR_JALR = 2'b11.
//    - PCnext_sel encodings.
//    - Stage-register struct typedefs if_id_t, id_ex_t, ex_mem_t.
//  - One sub-module, br_compare: combinational funct3 comparator.
//    Inputs rs1, rs2, funct3; output taken.
// TESTING
//  1. Assert rst_i mid-stream between clock edges -> all outputs 0 immediately; counters 0.
//  2. BEQ at PC 0x0000_0100, rs1=rs2=5, imm=0x40, btb_hit=0 -> at N+3:
//     decision=1, target=0x140, index=0x040, tag=0, mispredict=1, mispred_cnt=1.
//  3. BLTU then BLT, each with rs1=0xFFFF_FFFF, rs2=1 -> BLTU decision 0, BLT decision 1.
//  4. JALR with rs1=0x1003, imm=4, btb_hit=1 -> target=0x1006, is_uncbr=2'b11,
//     mispredict=1; br_cnt and mispred_cnt each increment by 1.
//  5. flush_i and stall_i asserted together while branches occupy IF/ID and ID/EX ->
//     neither branch ever reaches EXMEM_*; both counters unchanged.
//  6. CNT_WIDTH=4, 17 taken branches with btb_hit=1 -> br_cnt=0xF and stays there; mispred_cnt=0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared encodings and stage-register layouts for the branch commit path.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] UNCBR_JAL  = 2'b10;
    localparam logic [1:0] UNCBR_JALR = 2'b11;

    // Next-PC selector used by the predictor; 01/11 are the recovery paths fed from EX/MEM.
    localparam logic [1:0] PCSEL_SEQ     = 2'b00;
    localparam logic [1:0] PCSEL_PCPLUS4 = 2'b01;
    localparam logic [1:0] PCSEL_BTB     = 2'b10;
    localparam logic [1:0] PCSEL_TARGET  = 2'b11;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        btb_hit;
    } if_id_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        btb_hit;
        logic        is_br;
        logic [2:0]  funct3;
        logic [1:0]  is_uncbr;
    } id_ex_t;

    // btb_key is PC[31:2]; index and tag are carved out of it at the outputs.
    typedef struct packed {
        logic        valid;
        logic [29:0] btb_key;
        logic [31:0] pcplus4;
        logic [31:0] target;
        logic        btb_hit;
        logic        decision;
        logic        is_br;
        logic [1:0]  is_uncbr;
        logic        mispredict;
    } ex_mem_t;

endpackage

// File: rtl/branch_commit_unit_if.sv
// Pipeline-side inputs and predictor-facing resolution outputs of the branch commit unit.
interface branch_commit_unit_if #(
    parameter int INDEX_WIDTH = 12,
    parameter int CNT_WIDTH   = 32
);
    localparam int TAG_WIDTH = 32 - INDEX_WIDTH - 2;

    logic                   stall_i;
    logic                   flush_i;
    logic                   IF_valid_i;
    logic [31:0]            IF_pc_i;
    logic                   IF_btb_hit_i;
    logic                   ID_is_br_i;
    logic [2:0]             ID_br_funct3_i;
    logic [1:0]             ID_is_uncbr_i;
    logic [31:0]            EX_rs1_i;
    logic [31:0]            EX_rs2_i;
    logic [31:0]            EX_imm_i;

    logic [INDEX_WIDTH-1:0] EXMEM_btb_wr_index_o;
    logic [TAG_WIDTH-1:0]   EXMEM_btb_wr_tag_o;
    logic [31:0]            EXMEM_btb_wr_target_o;
    logic [31:0]            EXMEM_br_target_o;
    logic [31:0]            EXMEM_pcplus4_o;
    logic                   EXMEM_btb_hit_o;
    logic                   EXMEM_br_decision_o;
    logic                   EXMEM_is_br_o;
    logic [1:0]             EXMEM_is_uncbr_o;
    logic                   EXMEM_mispredict_o;
    logic [CNT_WIDTH-1:0]   br_cnt_o;
    logic [CNT_WIDTH-1:0]   mispred_cnt_o;

    modport master (
        input  stall_i, flush_i, IF_valid_i, IF_pc_i, IF_btb_hit_i,
               ID_is_br_i, ID_br_funct3_i, ID_is_uncbr_i,
               EX_rs1_i, EX_rs2_i, EX_imm_i,
        output EXMEM_btb_wr_index_o, EXMEM_btb_wr_tag_o, EXMEM_btb_wr_target_o,
               EXMEM_br_target_o, EXMEM_pcplus4_o, EXMEM_btb_hit_o,
               EXMEM_br_decision_o, EXMEM_is_br_o, EXMEM_is_uncbr_o,
               EXMEM_mispredict_o, br_cnt_o, mispred_cnt_o
    );

    modport slave (
        output stall_i, flush_i, IF_valid_i, IF_pc_i, IF_btb_hit_i,
               ID_is_br_i, ID_br_funct3_i, ID_is_uncbr_i,
               EX_rs1_i, EX_rs2_i, EX_imm_i,
        input  EXMEM_btb_wr_index_o, EXMEM_btb_wr_tag_o, EXMEM_btb_wr_target_o,
               EXMEM_br_target_o, EXMEM_pcplus4_o, EXMEM_btb_hit_o,
               EXMEM_br_decision_o, EXMEM_is_br_o, EXMEM_is_uncbr_o,
               EXMEM_mispredict_o, br_cnt_o, mispred_cnt_o
    );

endinterface

// File: rtl/br_compare.sv
// Conditional-branch condition evaluator keyed on funct3.
module br_compare
    import branch_pkg::*;
(
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [2:0]  funct3,
    output logic        taken
);

    // Encodings 010/011 are not branches and never resolve taken.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 <  rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_commit_unit.sv
// Carries BTB lookup results through IF/ID, ID/EX and EX/MEM, resolves branches in EX
// and presents the resolution to the predictor from the EX/MEM register.
module branch_commit_unit
    import branch_pkg::*;
#(
    parameter int INDEX_WIDTH = 12,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    branch_commit_unit_if.master bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    if_id_t               if_id_q, if_id_d;
    id_ex_t               id_ex_q, id_ex_d;
    ex_mem_t              ex_mem_q, ex_mem_d;
    ex_mem_t              ex_res_s;
    logic                 taken_s;
    logic                 is_jal_s;
    logic                 is_jalr_s;
    logic                 decision_s;
    logic [31:0]          jalr_sum_s;
    logic                 br_inc_s;
    logic                 mis_inc_s;
    logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

    br_compare u_br_compare (
        .rs1    (bus.EX_rs1_i),
        .rs2    (bus.EX_rs2_i),
        .funct3 (id_ex_q.funct3),
        .taken  (taken_s)
    );

    // EX resolution; an invalid EX slot produces an all-zero EX/MEM entry, which gates the outputs.
    always_comb begin
        ex_res_s   = '0;
        is_jal_s   = (id_ex_q.is_uncbr == UNCBR_JAL);
        is_jalr_s  = (id_ex_q.is_uncbr == UNCBR_JALR);
        jalr_sum_s = bus.EX_rs1_i + bus.EX_imm_i;
        if (id_ex_q.is_br) begin
            decision_s = taken_s;
        end else begin
            decision_s = is_jal_s | is_jalr_s;
        end
        if (id_ex_q.valid) begin
            ex_res_s.valid    = 1'b1;
            ex_res_s.btb_key  = id_ex_q.pc[31:2];
            ex_res_s.pcplus4  = id_ex_q.pc + 32'd4;
            ex_res_s.btb_hit  = id_ex_q.btb_hit;
            ex_res_s.decision = decision_s;
            ex_res_s.is_br    = id_ex_q.is_br;
            if (is_jalr_s) begin
                ex_res_s.target = {jalr_sum_s[31:1], 1'b0};
            end else begin
                ex_res_s.target = id_ex_q.pc + bus.EX_imm_i;
            end
            if (is_jal_s || is_jalr_s) begin
                ex_res_s.is_uncbr = id_ex_q.is_uncbr;
            end else begin
                ex_res_s.is_uncbr = 2'b00;
            end
            ex_res_s.mispredict = is_jalr_s |
                ((id_ex_q.is_br | is_jal_s) & (id_ex_q.btb_hit != decision_s));
        end else begin
            ex_res_s = '0;
        end
    end

    // Stage-register control: flush beats stall; EX/MEM always advances.
    always_comb begin
        if_id_d  = if_id_q;
        id_ex_d  = id_ex_q;
        ex_mem_d = ex_res_s;
        if (bus.flush_i) begin
            if_id_d  = '0;
            id_ex_d  = '0;
            ex_mem_d = '0;
        end else if (bus.stall_i) begin
            if_id_d  = if_id_q;
            id_ex_d  = '0;
            ex_mem_d = ex_res_s;
        end else begin
            if_id_d.valid    = bus.IF_valid_i;
            if_id_d.pc       = bus.IF_pc_i;
            if_id_d.btb_hit  = bus.IF_btb_hit_i;
            id_ex_d.valid    = if_id_q.valid;
            id_ex_d.pc       = if_id_q.pc;
            id_ex_d.btb_hit  = if_id_q.btb_hit;
            id_ex_d.is_br    = bus.ID_is_br_i;
            id_ex_d.funct3   = bus.ID_br_funct3_i;
            id_ex_d.is_uncbr = bus.ID_is_uncbr_i;
            ex_mem_d         = ex_res_s;
        end
    end

    // Saturating commit and misprediction counters.
    always_comb begin
        br_inc_s  = ex_mem_q.valid & (ex_mem_q.is_br | ex_mem_q.is_uncbr[1]);
        mis_inc_s = ex_mem_q.valid & ex_mem_q.mispredict;
        if (br_inc_s && (br_cnt_q != CNT_MAX)) begin
            br_cnt_d = br_cnt_q + CNT_ONE;
        end else begin
            br_cnt_d = br_cnt_q;
        end
        if (mis_inc_s && (mispred_cnt_q != CNT_MAX)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_ONE;
        end else begin
            mispred_cnt_d = mispred_cnt_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            if_id_q       <= '0;
            id_ex_q       <= '0;
            ex_mem_q      <= '0;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if_id_q       <= if_id_d;
            id_ex_q       <= id_ex_d;
            ex_mem_q      <= ex_mem_d;
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bus.EXMEM_btb_wr_index_o  = ex_mem_q.btb_key[INDEX_WIDTH-1:0];
    assign bus.EXMEM_btb_wr_tag_o    = ex_mem_q.btb_key[29:INDEX_WIDTH];
    assign bus.EXMEM_btb_wr_target_o = ex_mem_q.target;
    assign bus.EXMEM_br_target_o     = ex_mem_q.target;
    assign bus.EXMEM_pcplus4_o       = ex_mem_q.pcplus4;
    assign bus.EXMEM_btb_hit_o       = ex_mem_q.btb_hit;
    assign bus.EXMEM_br_decision_o   = ex_mem_q.decision;
    assign bus.EXMEM_is_br_o         = ex_mem_q.is_br;
    assign bus.EXMEM_is_uncbr_o      = ex_mem_q.is_uncbr;
    assign bus.EXMEM_mispredict_o    = ex_mem_q.mispredict;
    assign bus.br_cnt_o              = br_cnt_q;
    assign bus.mispred_cnt_o         = mispred_cnt_q;

endmodule
